// File: rtl/chip8_fb_pkg.sv
// rtl/chip8_fb_pkg.sv - shared framebuffer geometry and CPU operation codes
package chip8_fb_pkg;

   localparam int FB_DEPTH = 2048;
   localparam int FB_AW    = 11;

   typedef enum logic [1:0] {
      FB_READ  = 2'd0,
      FB_WRITE = 2'd1,
      FB_XOR   = 2'd2
   } cpu_op_t;

endpackage

// File: rtl/chip8_fb_arbiter.sv
// rtl/chip8_fb_arbiter.sv - time-slices one single-port framebuffer RAM between VGA scanout and the CPU
module chip8_fb_arbiter
   import chip8_fb_pkg::*;
#(
   parameter int FB_DEPTH = chip8_fb_pkg::FB_DEPTH,
   parameter int FB_AW    = chip8_fb_pkg::FB_AW
) (
   input  logic             clk50,
   input  logic             reset,
   input  logic [FB_AW-1:0] vga_addr,
   output logic             vga_pixel,
   input  logic             cpu_req,
   input  logic [1:0]       cpu_op,
   input  logic [FB_AW-1:0] cpu_addr,
   input  logic             cpu_wdata,
   output logic             cpu_ack,
   output logic             cpu_rdata,
   output logic             cpu_collision,
   input  logic             clear_start,
   output logic             clear_busy,
   output logic [FB_AW-1:0] ram_addr,
   output logic             ram_we,
   output logic             ram_wdata,
   input  logic             ram_rdata
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CLEAR  = 2'd1;
   localparam logic [1:0] ST_RMW_RD = 2'd2;
   localparam logic [1:0] ST_RMW_WR = 2'd3;

   localparam logic [FB_AW-1:0] CLR_LAST = FB_AW'(FB_DEPTH - 1);

   logic             phase;
   logic [1:0]       state;
   logic             clear_pend;
   logic [FB_AW-1:0] clr_cnt;
   logic             old_q;
   logic             rdata_q;
   logic             ack_is_read;
   logic             is_xor;
   logic             is_write;

   always_comb begin
      is_xor   = (cpu_op == FB_XOR);
      is_write = (cpu_op == FB_WRITE);
   end

   // A plain READ returns RAM data straight through on its ack cycle; otherwise the held value.
   assign cpu_rdata = (cpu_ack && ack_is_read) ? ram_rdata : rdata_q;

   always_comb begin
      ram_addr  = vga_addr;
      ram_we    = 1'b0;
      ram_wdata = 1'b0;
      if (phase) begin
         case (state)
            ST_IDLE: begin
               if (!clear_pend && cpu_req) begin
                  ram_addr  = cpu_addr;
                  ram_we    = is_write;
                  ram_wdata = cpu_wdata;
               end
            end
            ST_CLEAR: begin
               ram_addr = clr_cnt;
               ram_we   = 1'b1;
            end
            ST_RMW_RD: begin
               ram_addr  = cpu_addr;
               ram_we    = 1'b1;
               ram_wdata = old_q ^ cpu_wdata;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk50 or posedge reset) begin
      if (reset) begin
         phase         <= 1'b0;
         state         <= ST_IDLE;
         clear_pend    <= 1'b0;
         clr_cnt       <= '0;
         old_q         <= 1'b0;
         rdata_q       <= 1'b0;
         ack_is_read   <= 1'b0;
         vga_pixel     <= 1'b0;
         cpu_ack       <= 1'b0;
         cpu_collision <= 1'b0;
         clear_busy    <= 1'b0;
      end else begin
         phase   <= ~phase;
         cpu_ack <= 1'b0;
         if (phase)
            vga_pixel <= ram_rdata;
         if (clear_start && !clear_busy) begin
            clear_busy <= 1'b1;
            clear_pend <= 1'b1;
         end
         if (cpu_ack && ack_is_read)
            rdata_q <= ram_rdata;
         case (state)
            ST_IDLE: begin
               if (phase) begin
                  if (clear_pend) begin
                     state      <= ST_CLEAR;
                     clear_pend <= 1'b0;
                  end else if (cpu_req) begin
                     if (is_xor) begin
                        state <= ST_RMW_RD;
                     end else begin
                        cpu_ack       <= 1'b1;
                        ack_is_read   <= !is_write;
                        cpu_collision <= 1'b0;
                     end
                  end
               end
            end
            ST_RMW_RD: begin
               // VGA slot carries the read data back; the next CPU slot writes it toggled.
               if (!phase) begin
                  old_q <= ram_rdata;
               end else begin
                  state         <= ST_RMW_WR;
                  cpu_ack       <= 1'b1;
                  ack_is_read   <= 1'b0;
                  rdata_q       <= old_q;
                  cpu_collision <= old_q & cpu_wdata;
               end
            end
            ST_RMW_WR: state <= ST_IDLE;
            ST_CLEAR: begin
               if (phase) begin
                  if (clr_cnt == CLR_LAST) begin
                     clr_cnt    <= '0;
                     state      <= ST_IDLE;
                     clear_busy <= 1'b0;
                  end else begin
                     clr_cnt <= clr_cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_fb_arbiter.sv
// tb/tb_chip8_fb_arbiter.sv - self-checking bench for chip8_fb_arbiter
module tb_chip8_fb_arbiter;
   import chip8_fb_pkg::*;

   logic        clk50 = 1'b0;
   logic        reset;
   logic [10:0] vga_addr;
   logic        vga_pixel;
   logic        cpu_req;
   logic [1:0]  cpu_op;
   logic [10:0] cpu_addr;
   logic        cpu_wdata;
   logic        cpu_ack;
   logic        cpu_rdata;
   logic        cpu_collision;
   logic        clear_start;
   logic        clear_busy;
   logic [10:0] ram_addr;
   logic        ram_we;
   logic        ram_wdata;
   logic        ram_rdata;

   logic [2047:0] mem;
   logic [2047:0] fill_pat;
   logic          fill_en;
   logic [2047:0] ref_mem;
   logic          m_rdata;
   logic          m_coll;
   int            cyc;
   int            vga_we_viol = 0;
   int            passed;
   int            total;

   always #10 clk50 = ~clk50;

   chip8_fb_arbiter dut (
      .clk50         (clk50),
      .reset         (reset),
      .vga_addr      (vga_addr),
      .vga_pixel     (vga_pixel),
      .cpu_req       (cpu_req),
      .cpu_op        (cpu_op),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_ack       (cpu_ack),
      .cpu_rdata     (cpu_rdata),
      .cpu_collision (cpu_collision),
      .clear_start   (clear_start),
      .clear_busy    (clear_busy),
      .ram_addr      (ram_addr),
      .ram_we        (ram_we),
      .ram_wdata     (ram_wdata),
      .ram_rdata     (ram_rdata)
   );

   // Parent-side single-port RAM, read data one cycle after the address.
   always @(posedge clk50) begin
      if (fill_en)
         mem <= fill_pat;
      else if (ram_we)
         mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   always @(posedge clk50 or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   always @(negedge clk50) begin
      if (!reset && ram_we && !cyc[0])
         vga_we_viol <= vga_we_viol + 1;
   end

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic cpu_access(input logic [1:0] op, input logic [10:0] a, input logic d, input int exp_lat);
      int   slot;
      int   n;
      logic got_rd;
      logic got_co;
      logic old;
      cpu_op    = op;
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_req   = 1'b1;
      slot = cyc[0] ? cyc : cyc + 1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!cpu_ack && n < 10000);
      chk("ack_seen", cpu_ack, 1);
      chk("ack_latency", cyc - slot, exp_lat);
      got_rd  = cpu_rdata;
      got_co  = cpu_collision;
      cpu_req = 1'b0;
      old = ref_mem[a];
      if (op == FB_XOR) begin
         m_rdata    = old;
         m_coll     = old & d;
         ref_mem[a] = old ^ d;
      end else if (op == FB_WRITE) begin
         m_coll     = 1'b0;
         ref_mem[a] = d;
      end else begin
         m_rdata = old;
         m_coll  = 1'b0;
      end
      chk("cpu_rdata", got_rd, m_rdata);
      chk("cpu_collision", got_co, m_coll);
      tick();
      chk("ack_one_cycle", cpu_ack, 0);
      chk("ram_after_op", mem[a], ref_mem[a]);
   endtask

   initial begin
      logic [10:0] a;
      logic [1:0]  op;
      logic        d;
      int          n, busy_len, fall, ackc, early, slot, first_clr, we_cnt, bad_lo, bad_hi;
      logic        x_rd, x_co;

      reset = 1'b1; vga_addr = 11'd5; cpu_req = 1'b0; cpu_op = 2'd0; cpu_addr = '0;
      cpu_wdata = 1'b0; clear_start = 1'b0; fill_en = 1'b0;
      passed = 0; total = 0; m_rdata = 1'b0; m_coll = 1'b0;
      for (int i = 0; i < 2048; i++) fill_pat[i] = 1'($urandom_range(0, 1));
      fill_pat[5] = 1'b1;
      ref_mem = fill_pat;
      fill_en = 1'b1; tick(); fill_en = 1'b0; tick(); tick();

      chk("rst_vga_pixel", vga_pixel, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_cpu_collision", cpu_collision, 0);
      chk("rst_clear_busy", clear_busy, 0);
      chk("rst_ram_we", ram_we, 0);

      // Cycle 0 after release is a VGA slot presenting address 5.
      reset = 1'b0;
      tick();
      chk("vga_lat_cycle1", vga_pixel, 0);
      tick();
      chk("vga_lat_cycle2", vga_pixel, 1);

      for (int k = 0; k < 30; k++) begin
         if (cyc[0]) tick();
         a = 11'($urandom_range(0, 2047));
         vga_addr = a;
         tick(); tick();
         chk("vga_rand", vga_pixel, ref_mem[a]);
      end

      cpu_access(FB_WRITE, 11'd100, 1'b1, 1);
      cpu_access(FB_READ, 11'd100, 1'b0, 1);
      chk("rd100_value", cpu_rdata, 1);
      chk("rd100_coll", cpu_collision, 0);

      cpu_access(FB_WRITE, 11'd200, 1'b1, 1);
      cpu_access(FB_XOR, 11'd200, 1'b1, 3);
      chk("xor200_coll", cpu_collision, 1);
      chk("xor200_ram", mem[200], 0);
      cpu_access(FB_XOR, 11'd200, 1'b1, 3);
      chk("xor200b_coll", cpu_collision, 0);
      chk("xor200b_ram", mem[200], 1);

      for (int k = 0; k < 60; k++) begin
         op = 2'($urandom_range(0, 3));
         a  = 11'($urandom_range(0, 15));
         d  = 1'($urandom_range(0, 1));
         cpu_access(op, a, d, (op == FB_XOR) ? 3 : 1);
         for (int j = $urandom_range(0, 2); j > 0; j--) tick();
      end

      // Full clear over an all-ones screen, with a second request ignored mid-clear.
      fill_pat = '1; fill_en = 1'b1; tick(); fill_en = 1'b0; ref_mem = '1;
      clear_start = 1'b1; tick(); clear_start = 1'b0;
      busy_len = 0; n = 0;
      while (clear_busy && n < 6000) begin
         busy_len++;
         clear_start = (n == 2000);
         tick();
         n++;
      end
      clear_start = 1'b0;
      chk("clear_len_4096_to_4100", (busy_len >= 4096 && busy_len <= 4100), 1);
      chk("clear_all_zero", $countones(mem), 0);
      ref_mem = '0;
      for (int j = 0; j < 10; j++) tick();
      chk("second_clear_ignored", clear_busy, 0);

      // WRITE stalled by a clear.
      clear_start = 1'b1; tick(); clear_start = 1'b0;
      for (int j = 0; j < 100; j++) tick();
      cpu_op = FB_WRITE; cpu_addr = 11'd300; cpu_wdata = 1'b1; cpu_req = 1'b1;
      fall = -1; ackc = -1; early = 0; n = 0;
      while (ackc < 0 && n < 8000) begin
         tick();
         n++;
         if (!clear_busy && fall < 0) fall = cyc;
         if (cpu_ack) begin
            if (clear_busy) early = 1;
            ackc = cyc;
         end
      end
      cpu_req = 1'b0;
      chk("no_ack_during_clear", early, 0);
      chk("ack_within_2_after_clear", (fall >= 0 && ackc > fall && ackc - fall <= 2), 1);
      ref_mem[300] = 1'b1; m_coll = 1'b0;
      tick();
      chk("stalled_write_ram", mem[300], 1);

      // clear_start arriving during an XOR waits for the XOR ack.
      cpu_access(FB_WRITE, 11'd7, 1'b1, 1);
      if (!cyc[0]) tick();
      cpu_op = FB_XOR; cpu_addr = 11'd7; cpu_wdata = 1'b1; cpu_req = 1'b1; slot = cyc;
      tick();
      clear_start = 1'b1; tick(); clear_start = 1'b0;
      ackc = -1; first_clr = -1; n = 0; x_rd = 1'b0; x_co = 1'b0;
      while (first_clr < 0 && n < 100) begin
         if (cpu_ack && ackc < 0) begin
            ackc = cyc; x_rd = cpu_rdata; x_co = cpu_collision; cpu_req = 1'b0;
         end
         if (ram_we && ram_addr == 11'd0 && !ram_wdata && first_clr < 0) first_clr = cyc;
         tick();
         n++;
      end
      cpu_req = 1'b0;
      chk("xor_clr_ack_latency", ackc - slot, 3);
      chk("xor_clr_rdata", x_rd, 1);
      chk("xor_clr_coll", x_co, 1);
      chk("clear_after_xor_ack", (ackc >= 0 && first_clr > ackc), 1);
      n = 0;
      while (clear_busy && n < 6000) begin tick(); n++; end
      ref_mem = '0;
      chk("xor_then_clear_zero", $countones(mem), 0);

      // Reset with the clear counter at 1000.
      fill_pat = '1; fill_en = 1'b1; tick(); fill_en = 1'b0; ref_mem = '1;
      clear_start = 1'b1; tick(); clear_start = 1'b0;
      n = 0;
      while (!(ram_we && ram_addr == 11'd999) && n < 6000) begin tick(); n++; end
      chk("saw_clear_write_999", (ram_we && ram_addr == 11'd999), 1);
      tick();
      reset = 1'b1;
      #1;
      chk("rst_mid_clear_busy", clear_busy, 0);
      chk("rst_mid_clear_we", ram_we, 0);
      tick(); tick();
      reset = 1'b0;
      we_cnt = 0;
      for (int j = 0; j < 40; j++) begin
         tick();
         if (ram_we) we_cnt++;
      end
      chk("no_we_after_reset", we_cnt, 0);
      chk("busy_low_after_reset", clear_busy, 0);
      bad_lo = 0; bad_hi = 0;
      for (int i = 0; i < 1000; i++) if (mem[i] !== 1'b0) bad_lo++;
      for (int i = 1000; i < 2048; i++) if (mem[i] !== ref_mem[i]) bad_hi++;
      chk("cleared_below_1000", bad_lo, 0);
      chk("untouched_1000_up", bad_hi, 0);

      chk("no_we_in_vga_slot", vga_we_viol, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
